lcg_vec_source: RTL

- Synthesizable, parametrised stimulus source for the rewiring fuzz harness; replaces per-bench hand-unrolled LCG loops.
- Generates a programmable number of OUT_W-bit pseudo-random vectors from a 32-bit seed (LCG x' = x*0x41C64E6D + 0x3039 mod 2^32), filling 32-bit lanes LSB-first.
- Delivers vectors over a valid/ready stream with back-pressure, start/abort control and a done pulse; sits between bench control and the DUT's in_flat.

---
 rtl/lcg_vec_source.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/lcg_vec_source.sv
//==============================================================================
// Module      : lcg_vec_source
// Description : Parametrised pseudo-random vector source. Expands a 32-bit
//               seed with the LCG x' = x*0x41C64E6D + 0x3039 (mod 2^32) into
//               OUT_W-bit vectors, filling 32-bit lanes LSB-first, and
//               delivers a programmable number of them over a valid/ready
//               stream with start/abort control and a done pulse.
//               Optional running checksum enabled by the macro
//               LCG_VEC_SOURCE_CKSUM_EN (cksum tied to 0 when undefined).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module lcg_vec_source #(
    parameter int          OUT_W    = 140,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] DEF_SEED = 32'd1791895503
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      seed_in,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [OUT_W-1:0] vec_data,
    output logic [CNT_W-1:0] vec_idx,
    output logic [31:0]      cksum
);

    // Number of 32-bit lanes and the number of live bits in the top lane
    localparam int LANES  = (OUT_W + 31) / 32;
    localparam int LAST_W = OUT_W - 32 * (LANES - 1);

    localparam logic [31:0] c_MULT = 32'h41C6_4E6D;
    localparam logic [31:0] c_INC  = 32'h0000_3039;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_RUN  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    // One LCG step, wrapping naturally at 32 bits
    function automatic logic [31:0] lcg_step(input logic [31:0] x);
        return x * c_MULT + c_INC;
    endfunction

    state_t             r_fsm;
    logic [31:0]        r_lcg;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_idx;
    logic               r_valid;
    logic               r_done;
    logic [OUT_W-1:0]   r_vec;

    logic [31:0]        w_lane [LANES];
    logic [OUT_W-1:0]   w_vec;
    logic [31:0]        w_seed;
    logic               w_hshk;
    logic               w_last;

    // Unroll the LCG chain so every lane of the next vector is ready in one cycle
    always_comb begin
        logic [31:0] v;
        v = r_lcg;
        for (int k = 0; k < LANES; k++) begin
            v         = lcg_step(v);
            w_lane[k] = v;
        end
    end

    // Pack lanes LSB-first; the top lane is truncated to the live width
    always_comb begin
        w_vec = '0;
        for (int k = 0; k < LANES - 1; k++) begin
            w_vec[32*k +: 32] = w_lane[k];
        end
        w_vec[OUT_W-1 -: LAST_W] = w_lane[LANES-1][LAST_W-1:0];
    end

    assign w_seed = (seed_in == 32'd0) ? DEF_SEED : seed_in;
    assign w_hshk = r_valid && vec_ready;
    assign w_last = (r_idx == (r_count - CNT_W'(1)));

    // Control FSM: run setup, vector generation, handshake tracking, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_lcg   <= 32'd0;
            r_count <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_vec   <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_fsm != S_IDLE) && abort) begin
                // Abort wins over any handshake in the same cycle
                r_fsm   <= S_IDLE;
                r_valid <= 1'b0;
            end else begin
                case (r_fsm)
                    S_IDLE: begin
                        if (start) begin
                            r_lcg   <= w_seed;
                            r_count <= num_vec;
                            r_idx   <= '0;
                            r_fsm   <= (num_vec == '0) ? S_FIN : S_GEN;
                        end
                    end
                    S_GEN: begin
                        r_vec   <= w_vec;
                        r_lcg   <= w_lane[LANES-1];
                        r_valid <= 1'b1;
                        r_fsm   <= S_RUN;
                    end
                    S_RUN: begin
                        if (w_hshk) begin
                            if (w_last) begin
                                r_valid <= 1'b0;
                                r_fsm   <= S_FIN;
                            end else begin
                                // Next vector replaces the accepted one on the same edge
                                r_vec <= w_vec;
                                r_lcg <= w_lane[LANES-1];
                                r_idx <= r_idx + CNT_W'(1);
                            end
                        end
                    end
                    S_FIN: begin
                        r_done <= 1'b1;
                        r_fsm  <= S_IDLE;
                    end
                    default: begin
                        r_fsm   <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = (r_fsm != S_IDLE);
    assign done      = r_done;
    assign vec_valid = r_valid;
    assign vec_data  = r_vec;
    assign vec_idx   = r_idx;

`ifdef LCG_VEC_SOURCE_CKSUM_EN
    logic [31:0]            r_cksum;
    logic [LANES*32-1:0]    w_pad;
    logic [31:0]            w_fold;

    // XOR-fold the presented vector, top lane zero-extended
    always_comb begin
        w_pad            = '0;
        w_pad[OUT_W-1:0] = r_vec;
        w_fold           = 32'd0;
        for (int k = 0; k < LANES; k++) begin
            w_fold = w_fold ^ w_pad[32*k +: 32];
        end
    end

    // Running checksum: cleared at run start, updated on every accepted vector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cksum <= 32'd0;
        end else if ((r_fsm == S_IDLE) && start) begin
            r_cksum <= 32'd0;
        end else if ((r_fsm == S_RUN) && !abort && w_hshk) begin
            r_cksum <= {r_cksum[30:0], r_cksum[31]} ^ w_fold;
        end
    end

    assign cksum = r_cksum;
`else
    assign cksum = 32'd0;
`endif

endmodule

`default_nettype wire
